// File: rtl/gcn_aggregation_block.sv
// GCN aggregation: walks a COO edge list, accumulates FM_WM rows into agg[dst], then argmax per node.
// Define SELF_LOOP_EN to add an INIT phase that folds each node's own row in (A+I).
module gcn_aggregation_block #(
  parameter int FEATURE_ROWS    = 6,
  parameter int WEIGHT_COLS     = 3,
  parameter int DOT_PROD_WIDTH  = 16,
  parameter int NUM_EDGES       = 6,
  parameter int COO_WIDTH       = 3,
  parameter int EDGE_ADDR_WIDTH = 3,
  parameter int ACC_WIDTH       = 20,
  localparam int Y_WIDTH        = (WEIGHT_COLS > 1) ? $clog2(WEIGHT_COLS) : 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  output logic [EDGE_ADDR_WIDTH-1:0]           coo_address,
  input  logic [COO_WIDTH-1:0]                 coo_src,
  input  logic [COO_WIDTH-1:0]                 coo_dst,
  output logic [COO_WIDTH-1:0]                 read_row,
  input  logic [DOT_PROD_WIDTH*WEIGHT_COLS-1:0] FM_WM_Row,
  input  logic [COO_WIDTH-1:0]                 agg_row_sel,
  output logic [ACC_WIDTH*WEIGHT_COLS-1:0]     agg_row_out,
  output logic [Y_WIDTH*FEATURE_ROWS-1:0]      y,
  output logic                                 busy,
  output logic                                 done_agg
);

  // state  | meaning
  // IDLE   | waiting for start after reset
  // INIT   | issue self-loop rows 0..FEATURE_ROWS-1 (SELF_LOOP_EN only)
  // EDGE   | issue one COO edge per cycle
  // DRAIN  | last accumulate completes, no issue
  // ARGMAX | capture per-node argmax into y
  // DONE   | results held; start begins a new run
  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_EDGE, S_DRAIN, S_ARGMAX, S_DONE
  } state_t;

`ifdef SELF_LOOP_EN
  localparam state_t S_FIRST = S_INIT;
`else
  localparam state_t S_FIRST = S_EDGE;
`endif

  localparam logic [EDGE_ADDR_WIDTH-1:0] LAST_EDGE = EDGE_ADDR_WIDTH'(NUM_EDGES - 1);
  localparam logic [COO_WIDTH-1:0]       LAST_ROW  = COO_WIDTH'(FEATURE_ROWS - 1);
  localparam logic [COO_WIDTH:0]         ROW_LIMIT = (COO_WIDTH+1)'(FEATURE_ROWS);

  state_t                       r_state, w_next;
  logic [EDGE_ADDR_WIDTH-1:0]   r_edge_idx;
  logic [COO_WIDTH-1:0]         r_init_idx;
  logic [COO_WIDTH-1:0]         r_read_row_q;
  logic [COO_WIDTH-1:0]         r_dst;
  logic                         r_vld;
  logic [ACC_WIDTH-1:0]         r_agg [FEATURE_ROWS][WEIGHT_COLS];
  logic [Y_WIDTH*FEATURE_ROWS-1:0] r_y;

  logic                         w_start_run;
  logic                         w_issue;
  logic                         w_issue_ok;
  logic [COO_WIDTH-1:0]         w_issue_row;
  logic [COO_WIDTH-1:0]         w_issue_dst;
  logic [Y_WIDTH*FEATURE_ROWS-1:0] w_argmax;

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_start_run = 1'b0;
    w_issue     = 1'b0;
    w_issue_ok  = 1'b0;
    w_issue_row = r_read_row_q;
    w_issue_dst = r_dst;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_start_run = 1'b1;
          w_next      = S_FIRST;
        end
      end
      S_INIT: begin
        w_issue     = 1'b1;
        w_issue_ok  = 1'b1;
        w_issue_row = r_init_idx;
        w_issue_dst = r_init_idx;
        if (r_init_idx == LAST_ROW) w_next = S_EDGE;
      end
      S_EDGE: begin
        w_issue     = 1'b1;
        // out-of-range node indices are skipped but still consume their cycle
        w_issue_ok  = ({1'b0, coo_src} < ROW_LIMIT) && ({1'b0, coo_dst} < ROW_LIMIT);
        w_issue_row = coo_src;
        w_issue_dst = coo_dst;
        if (r_edge_idx == LAST_EDGE) w_next = S_DRAIN;
      end
      S_DRAIN:  w_next = S_ARGMAX;
      S_ARGMAX: w_next = S_DONE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_edge_idx   <= '0;
      r_init_idx   <= '0;
      r_read_row_q <= '0;
      r_dst        <= '0;
      r_vld        <= 1'b0;
    end else begin
      if (w_start_run) begin
        r_edge_idx <= '0;
        r_init_idx <= '0;
      end else begin
        if (r_state == S_EDGE && r_edge_idx != LAST_EDGE) r_edge_idx <= r_edge_idx + 1'b1;
        if (r_state == S_INIT && r_init_idx != LAST_ROW)  r_init_idx <= r_init_idx + 1'b1;
      end
      r_vld <= w_issue && w_issue_ok;
      if (w_issue) begin
        r_dst        <= w_issue_dst;
        r_read_row_q <= w_issue_row;
      end
    end
  end

  // Row data arrives one cycle after issue, so the registered dst/vld line up with FM_WM_Row.
  always_ff @(posedge clk) begin
    if (!reset || w_start_run) begin
      for (int i = 0; i < FEATURE_ROWS; i++)
        for (int c = 0; c < WEIGHT_COLS; c++)
          r_agg[i][c] <= '0;
    end else if (r_vld) begin
      for (int i = 0; i < FEATURE_ROWS; i++)
        if (r_dst == COO_WIDTH'(i))
          for (int c = 0; c < WEIGHT_COLS; c++)
            r_agg[i][c] <= r_agg[i][c]
                         + ACC_WIDTH'(FM_WM_Row[c*DOT_PROD_WIDTH +: DOT_PROD_WIDTH]);
    end
  end

  always_comb begin
    logic [ACC_WIDTH-1:0] best;
    logic [Y_WIDTH-1:0]   best_idx;
    w_argmax = '0;
    for (int i = 0; i < FEATURE_ROWS; i++) begin
      best     = r_agg[i][0];
      best_idx = '0;
      // strict compare keeps the lowest column on ties
      for (int c = 1; c < WEIGHT_COLS; c++) begin
        if (r_agg[i][c] > best) begin
          best     = r_agg[i][c];
          best_idx = Y_WIDTH'(c);
        end
      end
      w_argmax[i*Y_WIDTH +: Y_WIDTH] = best_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || w_start_run) r_y <= '0;
    else if (r_state == S_ARGMAX) r_y <= w_argmax;
  end

  always_comb begin
    agg_row_out = '0;
    for (int i = 0; i < FEATURE_ROWS; i++)
      if (agg_row_sel == COO_WIDTH'(i))
        for (int c = 0; c < WEIGHT_COLS; c++)
          agg_row_out[c*ACC_WIDTH +: ACC_WIDTH] = r_agg[i][c];
  end

  assign coo_address = r_edge_idx;
  assign read_row    = w_issue_row;
  assign y           = r_y;
  assign busy        = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done_agg    = (r_state == S_DONE);

endmodule

// File: tb/tb_gcn_aggregation_block.sv
// Directed bench for gcn_aggregation_block: FM_WM modelled as a 1-cycle-latency ROM, COO as a combinational ROM.
module tb_gcn_aggregation_block;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  coo_address;
  logic [2:0]  coo_src;
  logic [2:0]  coo_dst;
  logic [2:0]  read_row;
  logic [47:0] FM_WM_Row;
  logic [2:0]  agg_row_sel;
  logic [59:0] agg_row_out;
  logic [11:0] y;
  logic        busy;
  logic        done_agg;

  logic [15:0] rom_fm  [0:7][0:2];
  logic [2:0]  rom_src [0:7];
  logic [2:0]  rom_dst [0:7];

  int n_vec = 0;
  int n_mis = 0;
  int cyc;

  gcn_aggregation_block dut (
    .clk(clk), .reset(reset), .start(start),
    .coo_address(coo_address), .coo_src(coo_src), .coo_dst(coo_dst),
    .read_row(read_row), .FM_WM_Row(FM_WM_Row),
    .agg_row_sel(agg_row_sel), .agg_row_out(agg_row_out),
    .y(y), .busy(busy), .done_agg(done_agg)
  );

  always #5 clk = ~clk;

  assign coo_src = rom_src[coo_address];
  assign coo_dst = rom_dst[coo_address];

  always @(posedge clk)
    FM_WM_Row <= {rom_fm[read_row][2], rom_fm[read_row][1], rom_fm[read_row][0]};

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [59:0] pack_row(input int e0, input int e1, input int e2);
    return {20'(e2), 20'(e1), 20'(e0)};
  endfunction

  task automatic chk_row(input string tag, input int r, input int e0, input int e1, input int e2);
    agg_row_sel = 3'(r);
    #1;
    chk($sformatf("%s_agg%0d", tag, r), 64'(agg_row_out), 64'(pack_row(e0, e1, e2)));
  endtask

  task automatic chk_zero_rows(input string tag);
    for (int r = 0; r < 6; r++) chk_row(tag, r, 0, 0, 0);
  endtask

  task automatic clear_rom();
    for (int r = 0; r < 8; r++) begin
      // rows 6/7 carry junk so a missed skip would corrupt results
      rom_fm[r][0] = (r >= 6) ? 16'd100 : 16'd0;
      rom_fm[r][1] = (r >= 6) ? 16'd200 : 16'd0;
      rom_fm[r][2] = (r >= 6) ? 16'd300 : 16'd0;
      rom_src[r] = 3'd7;
      rom_dst[r] = 3'd1;
    end
  endtask

  task automatic set_row(input int r, input int a, input int b, input int c);
    rom_fm[r][0] = 16'(a);
    rom_fm[r][1] = 16'(b);
    rom_fm[r][2] = 16'(c);
  endtask

  task automatic set_edge(input int k, input int s, input int d);
    rom_src[k] = 3'(s);
    rom_dst[k] = 3'(d);
  endtask

  // Start a run from IDLE/DONE; cyc counts edges from the one that samples start to done_agg.
  task automatic run(input int pulse_at, input bit chk_clear, output int n);
    @(negedge clk);
    start = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
      start = (n == pulse_at);
      if (chk_clear && n == 1) begin
        chk("restart_done_low", 64'(done_agg), 64'd0);
        chk("restart_busy", 64'(busy), 64'd1);
        chk("restart_y_clear", 64'(y), 64'd0);
        chk_row("restart", 1, 0, 0, 0);
      end
    end while (!done_agg && n < 100);
    start = 1'b0;
  endtask

  task automatic load_sc2();
    clear_rom();
    set_row(0, 1, 2, 3);
    set_row(2, 4, 0, 1);
    set_edge(0, 0, 1);
    set_edge(1, 2, 1);
  endtask

  task automatic chk_sc2(input string tag, input int n);
    chk({tag, "_latency"}, 64'(n), 64'd9);
    chk_row(tag, 0, 0, 0, 0);
    chk_row(tag, 1, 5, 2, 4);
    chk_row(tag, 2, 0, 0, 0);
    chk_row(tag, 5, 0, 0, 0);
    chk({tag, "_y"}, 64'(y), 64'd0);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    agg_row_sel = 3'd0;
    clear_rom();

    // reset for two cycles
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done_agg), 64'd0);
    chk("rst_coo_address", 64'(coo_address), 64'd0);
    chk("rst_read_row", 64'(read_row), 64'd0);
    chk("rst_y", 64'(y), 64'd0);
    chk_zero_rows("rst");

`ifdef SELF_LOOP_EN
    // self loops only; all listed edges are out of range
    clear_rom();
    for (int i = 0; i < 6; i++) set_row(i, i, 0, 2);
    run(0, 1'b0, cyc);
    chk("sl_latency", 64'(cyc), 64'd15);
    chk("sl_done", 64'(done_agg), 64'd1);
    for (int i = 0; i < 6; i++) chk_row("sl", i, i, 0, 2);
    // rows [0,0,2],[1,0,2] -> 2; [2,0,2] ties -> 0; larger col0 -> 0
    chk("sl_y", 64'(y), 64'h00A);

    run(0, 1'b1, cyc);
    chk("sl_rerun_latency", 64'(cyc), 64'd15);
    chk_row("sl_rerun", 3, 3, 0, 2);
`else
    // two real edges into node 1, four pads from src 7
    load_sc2();
    run(0, 1'b0, cyc);
    chk("s2_done", 64'(done_agg), 64'd1);
    chk("s2_busy", 64'(busy), 64'd0);
    chk("s2_coo_address_hold", 64'(coo_address), 64'd5);
    chk_sc2("s2", cyc);

    // argmax patterns and dst-out-of-range skip
    clear_rom();
    set_row(0, 1, 2, 3);
    set_row(1, 7, 7, 7);
    set_row(2, 4, 0, 1);
    set_row(4, 1, 9, 9);
    set_row(5, 8, 8, 8);
    set_edge(0, 4, 0);
    set_edge(1, 2, 3);
    set_edge(2, 0, 2);
    set_edge(3, 1, 6);
    set_edge(4, 5, 7);
    set_edge(5, 7, 4);
    run(0, 1'b0, cyc);
    chk("am_latency", 64'(cyc), 64'd9);
    chk_row("am", 0, 1, 9, 9);
    chk_row("am", 2, 1, 2, 3);
    chk_row("am", 3, 4, 0, 1);
    chk_row("am", 4, 0, 0, 0);
    chk_row("am", 1, 0, 0, 0);
    chk("am_y", 64'(y), 64'h021);

    // six back-to-back edges to the same dst
    clear_rom();
    set_row(3, 65535, 1, 0);
    for (int k = 0; k < 6; k++) set_edge(k, 3, 5);
    run(0, 1'b0, cyc);
    chk("big_latency", 64'(cyc), 64'd9);
    chk_row("big", 5, 393210, 6, 0);
    chk_row("big", 3, 0, 0, 0);
    chk("big_y", 64'(y), 64'd0);

    // reset in the third EDGE cycle aborts the run
    load_sc2();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_busy_before", 64'(busy), 64'd1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done_agg), 64'd0);
    chk("abort_coo_address", 64'(coo_address), 64'd0);
    chk("abort_read_row", 64'(read_row), 64'd0);
    chk("abort_y", 64'(y), 64'd0);
    chk_zero_rows("abort");
    run(0, 1'b0, cyc);
    chk_sc2("s5", cyc);

    // start while busy is ignored; start in DONE clears and reruns
    run(3, 1'b0, cyc);
    chk_sc2("s6_busy_start", cyc);
    repeat (3) @(posedge clk);
    #1;
    chk("s6_hold_done", 64'(done_agg), 64'd1);
    chk_row("s6_hold", 1, 5, 2, 4);
    run(0, 1'b1, cyc);
    chk_sc2("s6_restart", cyc);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
